pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage pipelined CPU. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. It inserts load-use bubbles into ID/EX, flushes on taken branches resolved in EX, and freezes the whole pipeline while a data-memory access is outstanding. A watchdog on that memory wait drives a sticky error state.

## Interface
Parameters:
- MAX_WAIT, 16: max memory-wait cycles before the error state; legal range 2..255.
- CNT_W, 32: width of performance counters.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset; **synchronous, active-low**.
- idex_memread_i  in  1  MemRead currently held in ID/EX.
- idex_rdaddr_i  in  5  RDaddr currently held in ID/EX.
- ifid_rs1addr_i  in  5  rs1 of the instruction in ID.
- ifid_rs2addr_i  in  5  rs2 of the instruction in ID.
- branch_taken_i  in  1  branch in EX resolved taken.
- dmem_req_i  in  1  MEM stage issues a load or store this cycle.
- dmem_ack_i  in  1  data memory completes the access this cycle.
- pc_write_o  out  1  PC load enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID loads a NOP.
- idex_write_o  out  1  ID/EX load enable.
- idex_bubble_o  out  1  ID/EX loads all-zero control (ALUOp, ALUSrc, RegWrite, MemWrite, MemRead, Mem2Reg, Branch).
- exmem_write_o  out  1  EX/MEM and MEM/WB load enable.
- err_o  out  1  sticky memory-timeout error.
- stall_cycles_o  out  CNT_W  cycles with pc_write_o=0.
- flush_count_o  out  CNT_W  taken-branch flushes.

## Operation
FSM states:
- RUN
- MEM_WAIT
- ERR

Wait counter: `wait_cnt`, 8 bits.

Decisions in RUN, or in the ack cycle of MEM_WAIT, in priority order:
1. **Memory stall.** Condition: dmem_req_i=1 and dmem_ack_i=0.
   - All write enables 0; ifid_flush_o=0; idex_bubble_o=0.
   - Next state MEM_WAIT; wait_cnt←1.
2. **Taken branch.** Condition: branch_taken_i=1.
   - pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_write_o=1, idex_bubble_o=1, exmem_write_o=1.
3. **Load-use.** Condition: idex_memread_i=1, idex_rdaddr_i≠0, and idex_rdaddr_i equals ifid_rs1addr_i or ifid_rs2addr_i.
   - pc_write_o=0, ifid_write_o=0, idex_write_o=1, idex_bubble_o=1, exmem_write_o=1.
4. **Default.** All write enables 1; flush and bubble 0.

A branch and a load-use hazard in the same cycle resolve as a branch: the dependent instruction is being flushed anyway.

MEM_WAIT:
- dmem_ack_i=0: all enables held 0 and wait_cnt+1.
  - If wait_cnt reaches MAX_WAIT (cycle count including the entry cycle), next state is ERR.
- dmem_ack_i=1: this cycle is evaluated with rules 2–4 above, and the next state is RUN.
- dmem_req_i is ignored in MEM_WAIT; the requester holds it stable.

ERR:
- All enables 0; err_o=1.
- Exit only through reset.

Outputs are combinational from state and inputs; state, wait_cnt, err_o and the counters are registered.

## Timing
Stall latency:
- Stall and flush decisions take effect in the same cycle as the triggering input (zero latency).
- A load-use hazard costs exactly 1 bubble cycle.
- A memory access with ack N cycles after req (N≥1) holds the pipeline N cycles.
- A same-cycle ack costs 0 cycles.

Reset (rst_n_i=0 at a rising edge):
- state←RUN, wait_cnt←0, err_o←0, counters←0.
- While rst_n_i=0, outputs are forced: all write enables 1, ifid_flush_o=1, idex_bubble_o=1. This flushes the pipeline to NOPs.
- Reset during MEM_WAIT or ERR aborts that state immediately.

Counters:
- Saturate at all-ones; they never wrap.
- stall_cycles_o increments in every non-reset cycle with pc_write_o=0.
- flush_count_o increments on every rule-2 cycle.

## Configuration
Macro: `PIPE_HAZARD_PERF_CNT_EN`.
- Defined: both counters are implemented as above.
- Undefined: no counter registers exist; stall_cycles_o and flush_count_o are tied to 0.

## Structure
Package `pipe_ctrl_pkg` holds:
- the state enum (RUN, MEM_WAIT, ERR);
- constant REG_ZERO=5'd0;
- the control-bundle width.

Sub-module `pipe_wait_timer` contains the wait counter plus the timeout compare, parameterised by MAX_WAIT. It has inputs start, tick and clr, and output expired.

## Test plan
- **Load-use:** idex_memread_i=1, idex_rdaddr_i=5, ifid_rs2addr_i=5 → one cycle of pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_cycles_o=1.
- **x0 exclusion:** idex_rdaddr_i=0 with ifid_rs1addr_i=0 and memread=1 → no stall.
- **Taken branch:** branch_taken_i=1 together with a load-use match → ifid_flush_o=1, idex_bubble_o=1, pc_write_o=1; flush_count_o=1.
- **Memory wait:** dmem_req_i=1 with ack after 3 cycles → exmem_write_o=0 for 3 cycles, released on the ack cycle, state RUN the next cycle.
- **Timeout:** MAX_WAIT=4, req with no ack → ERR entered after 4 cycles, err_o=1 and all enables 0 persist; rst_n_i=0 for one edge → err_o=0, state RUN.
- **Reset mid-wait:** assert rst_n_i=0 in cycle 2 of MEM_WAIT → next cycle RUN, wait_cnt=0, counters=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// The control bundle is ordered MSB-first: pc, ifid_write, ifid_flush, idex_write, idex_bubble, exmem.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_RUN    = ctrl_t'(6'b110101);
  localparam ctrl_t CTRL_HOLD   = ctrl_t'(6'b000000);
  localparam ctrl_t CTRL_FLUSH  = ctrl_t'(6'b111111);
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(6'b000111);
  localparam ctrl_t CTRL_RST    = ctrl_t'(6'b111111);

  // Rules 2-4: a taken branch wins over load-use since the dependent op is flushed anyway.
  function automatic ctrl_t resolve(input logic branch_taken, input logic load_use);
    if (branch_taken) return CTRL_FLUSH;
    if (load_use)     return CTRL_BUBBLE;
    return CTRL_RUN;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs and pipeline control outputs of the hazard controller.
// master: the controller; slave: the datapath it sequences.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             idex_memread_i;
  logic [4:0]       idex_rdaddr_i;
  logic [4:0]       ifid_rs1addr_i;
  logic [4:0]       ifid_rs2addr_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_write_o;
  logic             idex_bubble_o;
  logic             exmem_write_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] flush_count_o;

  modport master (
    input  idex_memread_i, idex_rdaddr_i, ifid_rs1addr_i, ifid_rs2addr_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
           exmem_write_o, err_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    output idex_memread_i, idex_rdaddr_i, ifid_rs1addr_i, ifid_rs2addr_i,
           branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
           exmem_write_o, err_o, stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_wait_timer.sv
// Memory-wait cycle counter; expired flags that one more waiting cycle reaches MAX_WAIT.
module pipe_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start,
  input  logic tick,
  input  logic clr,
  output logic expired
);
  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)                        wait_cnt <= 8'd0;
    else if (start)                      wait_cnt <= 8'd1;
    else if (clr)                        wait_cnt <= 8'd0;
    else if (tick && wait_cnt != 8'hFF)  wait_cnt <= wait_cnt + 8'd1;
  end

  assign expired = (wait_cnt >= LAST);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use bubbles, branch flush, memory freeze.
// Optional performance counters are built when PIPE_HAZARD_PERF_CNT_EN is defined.
//   state    | meaning
//   RUN      | normal issue; hazards resolved combinationally
//   MEM_WAIT | data access outstanding; pipeline frozen until ack
//   ERR      | memory watchdog fired; frozen until reset
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  pipe_hazard_ctrl_if.master bus
);
  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   load_use;
  logic   tmr_start, tmr_tick, tmr_clr, tmr_expired;
  logic   err_q;

  assign load_use = bus.idex_memread_i && (bus.idex_rdaddr_i != REG_ZERO) &&
                    ((bus.idex_rdaddr_i == bus.ifid_rs1addr_i) ||
                     (bus.idex_rdaddr_i == bus.ifid_rs2addr_i));

  pipe_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start   (tmr_start),
    .tick    (tmr_tick),
    .clr     (tmr_clr),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ctrl      = CTRL_RUN;
    tmr_start = 1'b0;
    tmr_tick  = 1'b0;
    tmr_clr   = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.dmem_req_i && !bus.dmem_ack_i) begin
          ctrl      = CTRL_HOLD;
          state_d   = MEM_WAIT;
          tmr_start = 1'b1;
        end else begin
          ctrl = resolve(bus.branch_taken_i, load_use);
        end
      end
      MEM_WAIT: begin
        // dmem_req_i is deliberately ignored here; the requester holds it.
        if (!bus.dmem_ack_i) begin
          ctrl     = CTRL_HOLD;
          tmr_tick = 1'b1;
          if (tmr_expired) state_d = ERR;
        end else begin
          ctrl    = resolve(bus.branch_taken_i, load_use);
          state_d = RUN;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        ctrl    = CTRL_HOLD;
        state_d = ERR;
      end
    endcase
    if (!rst_n_i) ctrl = CTRL_RST;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)             err_q <= 1'b0;
    else if (state_d == ERR)  err_q <= 1'b1;
  end

  assign {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
          bus.idex_write_o, bus.idex_bubble_o, bus.exmem_write_o} = CTRL_W'(ctrl);
  assign bus.err_o = err_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_q, flush_q;

  // ifid_flush is only raised by a taken branch once reset is released.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctrl.pc_write && stall_q != '1)  stall_q <= stall_q + CNT_ONE;
      if (ctrl.ifid_flush && flush_q != '1) flush_q <= flush_q + CNT_ONE;
    end
  end

  assign bus.stall_cycles_o = stall_q;
  assign bus.flush_count_o  = flush_q;
`else
  assign bus.stall_cycles_o = '0;
  assign bus.flush_count_o  = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int MW = 4;
  localparam int CW = 4;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [5:0] P_RST  = 6'b111111;
  localparam logic [5:0] P_NORM = 6'b110101;
  localparam logic [5:0] P_HOLD = 6'b000000;
  localparam logic [5:0] P_FLSH = 6'b111111;
  localparam logic [5:0] P_BUBL = 6'b000111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus();

  pipe_hazard_ctrl #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model state: error flag, cycles stalled so far in the current memory access, counters.
  bit m_err   = 1'b0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic [5:0] dut_ctrl();
    return {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
            bus.idex_write_o, bus.idex_bubble_o, bus.exmem_write_o};
  endfunction

  function automatic logic [5:0] exp_ctrl();
    bit lu;
    lu = bus.idex_memread_i && (bus.idex_rdaddr_i != 5'd0) &&
         (bus.idex_rdaddr_i == bus.ifid_rs1addr_i || bus.idex_rdaddr_i == bus.ifid_rs2addr_i);
    if (!rst_n)                                        return P_RST;
    if (m_err)                                         return P_HOLD;
    if (m_wait > 0 && !bus.dmem_ack_i)                 return P_HOLD;
    if (m_wait == 0 && bus.dmem_req_i && !bus.dmem_ack_i) return P_HOLD;
    if (bus.branch_taken_i)                            return P_FLSH;
    if (lu)                                            return P_BUBL;
    return P_NORM;
  endfunction

  always @(negedge clk) begin
    logic [5:0] e;
    int es;
    int cmax;
    e    = exp_ctrl();
    es   = m_err ? int'(ERR) : (m_wait > 0 ? int'(MEM_WAIT) : int'(RUN));
    cmax = (1 << CW) - 1;
    chk("ctrl", 32'(dut_ctrl()), 32'(e));
    chk("err", 32'(bus.err_o), 32'(m_err));
    chk("stall_cnt", 32'(bus.stall_cycles_o), PERF ? m_stall : 0);
    chk("flush_cnt", 32'(bus.flush_count_o), PERF ? m_flush : 0);
    chk("state", 32'(dut.state_q), es);
    if (!m_err) chk("wait_cnt", 32'(dut.u_timer.wait_cnt), m_wait);
    if (!rst_n) begin
      m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e[5] && m_stall < cmax) m_stall++;
      if (e == P_FLSH && m_flush < cmax) m_flush++;
      if (!m_err) begin
        if (m_wait > 0) begin
          if (bus.dmem_ack_i) m_wait = 0;
          else begin
            m_wait++;
            if (m_wait >= MW) m_err = 1'b1;
          end
        end else if (bus.dmem_req_i && !bus.dmem_ack_i) begin
          m_wait = 1;
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input bit br, input bit req, input bit ack);
    @(posedge clk); #1;
    rst_n              = r;
    bus.idex_memread_i = mr;
    bus.idex_rdaddr_i  = rd;
    bus.ifid_rs1addr_i = rs1;
    bus.ifid_rs2addr_i = rs2;
    bus.branch_taken_i = br;
    bus.dmem_req_i     = req;
    bus.dmem_ack_i     = ack;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.idex_memread_i = 0; bus.idex_rdaddr_i = 0; bus.ifid_rs1addr_i = 0;
    bus.ifid_rs2addr_i = 0; bus.branch_taken_i = 0; bus.dmem_req_i = 0; bus.dmem_ack_i = 0;

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_ctrl", 32'(dut_ctrl()), 32'(P_RST));
    idle();
    chk("idle_ctrl", 32'(dut_ctrl()), 32'(P_NORM));
    chk("rst_err", 32'(bus.err_o), 0);
    chk("rst_stall", 32'(bus.stall_cycles_o), 0);

    cyc(1, 1, 5, 3, 5, 0, 0, 0);
    chk("lu_ctrl", 32'(dut_ctrl()), 32'(P_BUBL));
    idle();
    chk("lu_release", 32'(dut_ctrl()), 32'(P_NORM));
    chk("lu_stall", 32'(bus.stall_cycles_o), PERF ? 1 : 0);

    cyc(1, 1, 0, 0, 7, 0, 0, 0);
    chk("x0_ctrl", 32'(dut_ctrl()), 32'(P_NORM));
    idle();
    chk("x0_stall", 32'(bus.stall_cycles_o), PERF ? 1 : 0);

    cyc(1, 1, 5, 5, 0, 1, 0, 0);
    chk("br_ctrl", 32'(dut_ctrl()), 32'(P_FLSH));
    idle();
    chk("br_flush", 32'(bus.flush_count_o), PERF ? 1 : 0);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 1, 0);
      chk("mw_hold", 32'(bus.exmem_write_o), 0);
    end
    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    chk("mw_ack", 32'(dut_ctrl()), 32'(P_NORM));
    idle();
    chk("mw_state", 32'(dut.state_q), int'(RUN));
    chk("mw_stall", 32'(bus.stall_cycles_o), PERF ? 4 : 0);

    cyc(1, 0, 0, 0, 0, 0, 1, 1);
    chk("ack0_ctrl", 32'(dut_ctrl()), 32'(P_NORM));
    idle();
    chk("ack0_state", 32'(dut.state_q), int'(RUN));

    for (int i = 0; i < MW; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 1, 0);
      chk("to_hold", 32'(dut_ctrl()), 32'(P_HOLD));
      chk("to_noerr", 32'(bus.err_o), 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 5, 5, 5, 1, 1, 1);
      chk("err_flag", 32'(bus.err_o), 1);
      chk("err_ctrl", 32'(dut_ctrl()), 32'(P_HOLD));
      chk("err_state", 32'(dut.state_q), int'(ERR));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_rst_ctrl", 32'(dut_ctrl()), 32'(P_RST));
    idle();
    chk("err_cleared", 32'(bus.err_o), 0);
    chk("err_rst_state", 32'(dut.state_q), int'(RUN));

    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    chk("mid_state", 32'(dut.state_q), int'(MEM_WAIT));
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    chk("mid_run", 32'(dut.state_q), int'(RUN));
    chk("mid_wait", 32'(dut.u_timer.wait_cnt), 0);
    chk("mid_stall", 32'(bus.stall_cycles_o), 0);
    chk("mid_flush", 32'(bus.flush_count_o), 0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst_n              = ($urandom_range(63) != 0);
      bus.idex_memread_i = 1'($urandom_range(1));
      bus.idex_rdaddr_i  = 5'($urandom_range(3));
      bus.ifid_rs1addr_i = 5'($urandom_range(3));
      bus.ifid_rs2addr_i = 5'($urandom_range(3));
      bus.branch_taken_i = ($urandom_range(6) == 0);
      bus.dmem_req_i     = ($urandom_range(3) == 0);
      bus.dmem_ack_i     = ($urandom_range(2) == 0);
    end
    @(negedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
